// File: rtl/psum_accum_if.sv
// rtl/psum_accum_if.sv - beat input / vector output stream bundle for psum_accum
// Purpose: carries the upstream partial-sum beat stream (s_*) and the downstream
//          saturated vector stream (m_*) of one accumulator.
// Signals:
//   s_valid/s_ready  input beat handshake
//   s_data  [N*PB]   per-lane signed partial sums
//   m_valid/m_ready  output vector handshake
//   m_data  [N*XB]   per-lane signed saturated result
//   m_sat   [N]      per-lane saturation flag
// Modports: slave = accumulator side, master = feeder/consumer side.
interface psum_accum_if #(
    parameter int N  = 1,
    parameter int PB = 16,
    parameter int XB = 8
);
    logic            s_valid;
    logic            s_ready;
    logic [N*PB-1:0] s_data;
    logic            m_valid;
    logic            m_ready;
    logic [N*XB-1:0] m_data;
    logic [N-1:0]    m_sat;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, m_sat
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, m_sat
    );
endinterface

// File: rtl/psum_accum.sv
// rtl/psum_accum.sv - K-beat partial-sum accumulator with bias, shift and saturation
// Purpose: sums k_len signed beats per output vector (N lanes), adds a per-lane bias
//          captured on the first beat, arithmetic-shifts right by SH (truncating) and
//          clips to signed XB bits. The output register is independent of the
//          accumulator so the next vector accumulates while the current one drains.
// Ports:
//   clk    in  1      clock, rising edge
//   rst    in  1      asynchronous active-high reset
//   k_len  in  KW     beats per vector (0 treated as 1), sampled on first beat
//   bias   in  N*BB   per-lane signed bias, sampled on first beat
//   bus    slave modport of psum_accum_if (s_* beat stream in, m_* vector stream out)
module psum_accum #(
    parameter int N     = 1,
    parameter int PB    = 16,
    parameter int BB    = 16,
    parameter int K_MAX = 256,
    parameter int SH    = 8,
    parameter int XB    = 8,
    parameter int KW    = $clog2(K_MAX + 1),
    parameter int AB    = PB + $clog2(K_MAX) + 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [KW-1:0]   k_len,
    input  logic [N*BB-1:0] bias,
    psum_accum_if.slave     bus
);

    localparam logic signed [AB-1:0] SAT_MAX = AB'((1 << (XB - 1)) - 1);
    localparam logic signed [AB-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic {
        S_IDLE,
        S_ACC
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [KW-1:0]         r_cnt;
    logic [KW-1:0]         r_kl;
    logic signed [AB-1:0]  r_acc [N];
    logic                  r_m_valid;
    logic [N*XB-1:0]       r_m_data;
    logic [N-1:0]          r_m_sat;

    logic                  w_first;
    logic                  w_last;
    logic                  w_s_ready;
    logic                  w_accept;
    logic [KW-1:0]         w_kl_eff;
    logic signed [AB-1:0]  w_base [N];
    logic signed [AB-1:0]  w_sum  [N];
    logic signed [AB-1:0]  w_t    [N];
    logic [N*XB-1:0]       w_res;
    logic [N-1:0]          w_sat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // The beat length comes from k_len on the first beat and from the latch after it,
    // so a mid-vector k_len change cannot move the last-beat position.
    always_comb begin
        w_state_nxt = r_state;
        w_first     = (r_state == S_IDLE);
        w_kl_eff    = w_first ? ((k_len == '0) ? KW'(1) : k_len) : r_kl;
        w_last      = w_first ? (w_kl_eff == KW'(1)) : (r_cnt == r_kl - KW'(1));
        // Only a would-be last beat can stall, and only while the output is full and held.
        w_s_ready   = !w_last || !r_m_valid || bus.m_ready;
        w_accept    = bus.s_valid && w_s_ready;
        if (w_accept) begin
            w_state_nxt = w_last ? S_IDLE : S_ACC;
        end
    end

    always_comb begin
        w_res = '0;
        w_sat = '0;
        for (int n = 0; n < N; n++) begin
            w_base[n] = w_first ? AB'($signed(bias[n*BB +: BB])) : r_acc[n];
            w_sum[n]  = w_base[n] + AB'($signed(bus.s_data[n*PB +: PB]));
            w_t[n]    = w_sum[n] >>> SH;
            if (w_t[n] > SAT_MAX) begin
                w_res[n*XB +: XB] = XB'(SAT_MAX);
                w_sat[n]          = 1'b1;
            end else if (w_t[n] < SAT_MIN) begin
                w_res[n*XB +: XB] = XB'(SAT_MIN);
                w_sat[n]          = 1'b1;
            end else begin
                w_res[n*XB +: XB] = w_t[n][XB-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_kl      <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_sat   <= '0;
            for (int n = 0; n < N; n++) begin
                r_acc[n] <= '0;
            end
        end else begin
            if (w_accept) begin
                if (w_first) begin
                    r_kl <= w_kl_eff;
                end
                if (w_last) begin
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + KW'(1);
                    for (int n = 0; n < N; n++) begin
                        r_acc[n] <= w_sum[n];
                    end
                end
            end
            // A last beat landing on the same edge as a take reloads instead of clearing.
            if (w_accept && w_last) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_res;
                r_m_sat   <= w_sat;
            end else if (bus.m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign bus.m_sat   = r_m_sat;

    k_len_range_a: assert property (@(posedge clk) disable iff (rst)
        (bus.s_valid && w_s_ready && w_first) |-> (k_len <= KW'(K_MAX)));

endmodule

// File: tb/tb_psum_accum.sv
// tb/tb_psum_accum.sv - scoreboard bench for psum_accum (2-lane SH=0 and 1-lane SH=4 instances)
module tb_psum_accum;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [8:0]  k_len_a = '0;
    logic [31:0] bias_a  = '0;
    logic [8:0]  k_len_b = '0;
    logic [15:0] bias_b  = '0;

    always #5 clk = ~clk;

    psum_accum_if #(.N(2), .PB(16), .XB(8)) ifa ();
    psum_accum_if #(.N(1), .PB(16), .XB(8)) ifb ();

    psum_accum #(.N(2), .PB(16), .BB(16), .K_MAX(256), .SH(0), .XB(8)) dut_a (
        .clk(clk), .rst(rst), .k_len(k_len_a), .bias(bias_a), .bus(ifa.slave)
    );

    psum_accum #(.N(1), .PB(16), .BB(16), .K_MAX(256), .SH(4), .XB(8)) dut_b (
        .clk(clk), .rst(rst), .k_len(k_len_b), .bias(bias_b), .bus(ifb.slave)
    );

    int n_vec  = 0;
    int n_miss = 0;

    logic [17:0] exp_a [$];
    logic [8:0]  exp_b [$];

    function automatic logic [17:0] ea(input logic [1:0] sat, input int l1, input int l0);
        return {sat, 8'(l1), 8'(l0)};
    endfunction

    function automatic logic [8:0] eb(input logic sat, input int v);
        return {sat, 8'(v)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic beat_a(input int kl, input int b0, input int b1, input int d0, input int d1,
                          output int waited);
        k_len_a     = 9'(kl);
        bias_a      = {16'(b1), 16'(b0)};
        ifa.s_data  = {16'(d1), 16'(d0)};
        ifa.s_valid = 1'b1;
        waited      = 0;
        @(negedge clk);
        while (!ifa.s_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!ifa.s_ready) begin
            n_vec++;
            n_miss++;
            $display("FAIL beat_a_timeout: s_ready still 0 after %0d cycles", waited);
        end
        @(posedge clk);
        #1;
        ifa.s_valid = 1'b0;
    endtask

    task automatic beat_b(input int kl, input int b, input int d);
        int waited;
        k_len_b     = 9'(kl);
        bias_b      = 16'(b);
        ifb.s_data  = 16'(d);
        ifb.s_valid = 1'b1;
        waited      = 0;
        @(negedge clk);
        while (!ifb.s_ready && waited < 20) begin
            waited++;
            @(negedge clk);
        end
        if (!ifb.s_ready) begin
            n_vec++;
            n_miss++;
            $display("FAIL beat_b_timeout: s_ready still 0 after %0d cycles", waited);
        end
        @(posedge clk);
        #1;
        ifb.s_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (!rst && ifa.m_valid && ifa.m_ready) begin
            n_vec++;
            if (exp_a.size() == 0) begin
                n_miss++;
                $display("FAIL mon_a_unexpected: got %0h with empty scoreboard", {ifa.m_sat, ifa.m_data});
            end else begin
                logic [17:0] e;
                e = exp_a.pop_front();
                if ({ifa.m_sat, ifa.m_data} !== e) begin
                    n_miss++;
                    $display("FAIL mon_a_vector: got %0h expected %0h", {ifa.m_sat, ifa.m_data}, e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && ifb.m_valid && ifb.m_ready) begin
            n_vec++;
            if (exp_b.size() == 0) begin
                n_miss++;
                $display("FAIL mon_b_unexpected: got %0h with empty scoreboard", {ifb.m_sat, ifb.m_data});
            end else begin
                logic [8:0] e;
                e = exp_b.pop_front();
                if ({ifb.m_sat, ifb.m_data} !== e) begin
                    n_miss++;
                    $display("FAIL mon_b_vector: got %0h expected %0h", {ifb.m_sat, ifb.m_data}, e);
                end
            end
        end
    end

    initial begin
        int w;
        int t;
        ifa.s_valid = 1'b0;
        ifa.s_data  = '0;
        ifa.m_ready = 1'b1;
        ifb.s_valid = 1'b0;
        ifb.s_data  = '0;
        ifb.m_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_a_m_valid", 32'(ifa.m_valid), 32'd0);
        chk("rst_a_m_data",  32'(ifa.m_data),  32'd0);
        chk("rst_a_m_sat",   32'(ifa.m_sat),   32'd0);
        chk("rst_a_s_ready", 32'(ifa.s_ready), 32'd1);
        chk("rst_b_m_valid", 32'(ifb.m_valid), 32'd0);
        chk("rst_b_m_data",  32'(ifb.m_data),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: K=4, bias {10,-10}, data 1..4 per lane -> {20, 0}
        beat_a(4, 10, -10, 1, 1, w);
        beat_a(4, 10, -10, 2, 2, w);
        beat_a(4, 10, -10, 3, 3, w);
        chk("t1_no_early_valid", 32'(ifa.m_valid), 32'd0);
        exp_a.push_back(ea(2'b00, 0, 20));
        beat_a(4, 10, -10, 4, 4, w);
        chk("t1_valid_latency", 32'(ifa.m_valid), 32'd1);

        // 2: K=1 back-to-back, never stalled, value = bias + data
        exp_a.push_back(ea(2'b00, -1, 8));
        beat_a(1, 5, -5, 3, 4, w);
        chk("t2_ready_0", 32'(w), 32'd0);
        exp_a.push_back(ea(2'b00, -105, 105));
        beat_a(1, 5, -5, 100, -100, w);
        chk("t2_ready_1", 32'(w), 32'd0);
        exp_a.push_back(ea(2'b00, 2, -2));
        beat_a(1, 5, -5, -7, 7, w);
        chk("t2_ready_2", 32'(w), 32'd0);
        exp_a.push_back(ea(2'b00, 60, 50));
        beat_a(1, 0, 0, 50, 60, w);
        chk("t2_ready_3", 32'(w), 32'd0);

        // 3: K=3 with the output held; only the last beat of vector 2 stalls
        @(posedge clk);
        #1;
        ifa.m_ready = 1'b0;
        exp_a.push_back(ea(2'b00, 6, 6));
        beat_a(3, 0, 0, 1, 1, w);
        beat_a(3, 0, 0, 2, 2, w);
        beat_a(3, 0, 0, 3, 3, w);
        chk("t3_v1_valid", 32'(ifa.m_valid), 32'd1);
        beat_a(3, 1, 1, 10, -1, w);
        chk("t3_v2_beat1_ready", 32'(w), 32'd0);
        beat_a(3, 1, 1, 20, -2, w);
        chk("t3_v2_beat2_ready", 32'(w), 32'd0);
        ifa.s_data  = {16'(-3), 16'(30)};
        ifa.s_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("t3_last_stalled", 32'(ifa.s_ready), 32'd0);
        end
        chk("t3_v1_held", 32'({ifa.m_sat, ifa.m_data}), 32'(ea(2'b00, 6, 6)));
        exp_a.push_back(ea(2'b00, -5, 61));
        @(posedge clk);
        #1;
        ifa.m_ready = 1'b1;
        @(negedge clk);
        chk("t3_released", 32'(ifa.s_ready), 32'd1);
        @(posedge clk);
        #1;
        ifa.s_valid = 1'b0;
        chk("t3_v2_valid", 32'(ifa.m_valid), 32'd1);

        // 5: reset mid-vector with a full output register
        @(posedge clk);
        #1;
        ifa.m_ready = 1'b0;
        beat_a(1, 0, 0, 200, -200, w);
        chk("t5_pre_sat", 32'(ifa.m_sat), 32'd3);
        beat_a(4, 100, 100, 1, 1, w);
        beat_a(4, 100, 100, 1, 1, w);
        rst = 1'b1;
        #1;
        chk("t5_rst_m_valid", 32'(ifa.m_valid), 32'd0);
        chk("t5_rst_m_data",  32'(ifa.m_data),  32'd0);
        chk("t5_rst_m_sat",   32'(ifa.m_sat),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ifa.m_ready = 1'b1;
        exp_a.push_back(ea(2'b00, 12, 8));
        beat_a(4, 0, 0, 2, 3, w);
        beat_a(4, 0, 0, 2, 3, w);
        beat_a(4, 0, 0, 2, 3, w);
        chk("t5_no_residue_early", 32'(ifa.m_valid), 32'd0);
        beat_a(4, 0, 0, 2, 3, w);
        chk("t5_fresh_valid", 32'(ifa.m_valid), 32'd1);

        // 6: k_len=0 acts as 1; k_len/bias changes mid-vector are ignored
        exp_a.push_back(ea(2'b00, 10, 8));
        beat_a(0, 3, 4, 5, 6, w);
        chk("t6_klen0_valid", 32'(ifa.m_valid), 32'd1);
        exp_a.push_back(ea(2'b00, 23, 12));
        beat_a(2, 1, 2, 10, 20, w);
        chk("t6_mid_not_valid", 32'(ifa.m_valid), 32'd0);
        beat_a(5, 100, 100, 1, 1, w);
        chk("t6_end_valid", 32'(ifa.m_valid), 32'd1);

        // 4: SH=4 saturation and truncating shift on the 1-lane instance
        exp_b.push_back(eb(1'b1, 127));
        beat_b(2, 1000, 2000);
        beat_b(2, 0, 2000);
        exp_b.push_back(eb(1'b1, -128));
        beat_b(2, -1000, -2000);
        beat_b(2, 0, -2000);
        exp_b.push_back(eb(1'b0, -2));
        beat_b(1, -20, 3);
        exp_b.push_back(eb(1'b0, 127));
        beat_b(1, 0, 2047);
        exp_b.push_back(eb(1'b1, 127));
        beat_b(1, 0, 2048);
        exp_b.push_back(eb(1'b0, -128));
        beat_b(1, 0, -2048);
        exp_b.push_back(eb(1'b1, -128));
        beat_b(1, 48, -2097);

        t = 0;
        while ((exp_a.size() != 0 || exp_b.size() != 0) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (exp_a.size() != 0 || exp_b.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL drain: %0d/%0d vectors never produced, expected 0/0", exp_a.size(), exp_b.size());
        end
        @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
